// File: rtl/i2s_microphones.sv
// I2S receiver for a stereo MEMS microphone pair: generates mic_sck/mic_ws from
// clk_in and deserialises mic_data MSB-first into one signed sample per slot.
module i2s_microphones #(
  parameter int unsigned SCK_HALF_PERIOD = 16,
  parameter int unsigned SAMPLE_WIDTH    = 24
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           mic_data,
  output logic                           mic_sck,
  output logic                           mic_ws,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_channel,
  output logic                           sample_valid
);

  localparam int unsigned       CNT_W    = $clog2(SCK_HALF_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCK_HALF_PERIOD - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             half_wrap;
  logic             sck_fall;
  logic [1:0]       sync;
  logic [5:0]       bit_cnt;
  logic [31:0]      shift;
  logic [31:0]      word;
  logic             unused_bits;

  assign half_wrap = (half_cnt == CNT_LAST);
  assign sck_fall  = half_wrap && mic_sck;

  // Completed word including the bit being captured on this falling edge.
  assign word   = {shift[30:0], sync[1]};
  assign mic_ws = bit_cnt[5];

  assign unused_bits = ^{shift[31], word};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      half_cnt <= '0;
      mic_sck  <= 1'b0;
    end else if (half_wrap) begin
      half_cnt <= '0;
      mic_sck  <= ~mic_sck;
    end else begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], mic_data};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (sck_fall) begin
      bit_cnt <= bit_cnt + 6'd1;
      shift   <= word;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sample_out     <= '0;
      sample_channel <= 1'b0;
      sample_valid   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sck_fall && (bit_cnt[4:0] == 5'd31)) begin
        sample_out     <= word[31 -: SAMPLE_WIDTH];
        sample_channel <= bit_cnt[5];
        sample_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_microphones.sv
// Self-checking bench for i2s_microphones: per-cycle reference of the I2S frame
// timing plus a slot-word table that predicts every strobed sample.
module tb_i2s_microphones;

  localparam int T     = 16;
  localparam int SW    = 24;
  localparam int SLOT  = 64 * T;
  localparam int FRAME = 128 * T;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 mic_data;
  logic                 mic_sck;
  logic                 mic_ws;
  logic signed [SW-1:0] sample_out;
  logic                 sample_channel;
  logic                 sample_valid;

  i2s_microphones #(
    .SCK_HALF_PERIOD(T),
    .SAMPLE_WIDTH   (SW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .mic_data      (mic_data),
    .mic_sck       (mic_sck),
    .mic_ws        (mic_ws),
    .sample_out    (sample_out),
    .sample_channel(sample_channel),
    .sample_valid  (sample_valid)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          passed = 0;
  int          cyc;
  bit          in_reset;
  logic [31:0] slot_word [0:63];
  logic [SW-1:0] got [0:63];
  logic [SW-1:0] held;
  logic        prev_sck, prev_ws;
  int          first_sck, first_ws, last_rise, last_ws_rise, last_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [SW-1:0] top_bits(input logic [31:0] w);
    top_bits = w[31 -: SW];
  endfunction

  // Microphone model: bit k of a slot is valid throughout the high half of
  // bit period k; the low half carries noise that must never be captured.
  task automatic drive();
    int p;
    if (((cyc / T) % 2) == 1) begin
      p = cyc / (2 * T);
      mic_data = slot_word[p / 32][31 - (p % 32)];
    end else begin
      mic_data = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_tracking();
    prev_sck     = 1'b0;
    prev_ws      = 1'b0;
    first_sck    = -1;
    first_ws     = -1;
    last_rise    = -1;
    last_ws_rise = -1;
    last_valid   = -1;
    held         = '0;
    for (int i = 0; i < 64; i++) got[i] = '0;
  endtask

  task automatic check_zero(input string tag);
    logic [SW-1:0] so_u;
    so_u = sample_out;
    check({tag, "_sck"},     32'(mic_sck),        32'd0);
    check({tag, "_ws"},      32'(mic_ws),         32'd0);
    check({tag, "_sample"},  32'(so_u),           32'd0);
    check({tag, "_channel"}, 32'(sample_channel), 32'd0);
    check({tag, "_valid"},   32'(sample_valid),   32'd0);
  endtask

  task automatic step();
    int            s;
    bit            exp_valid;
    logic [SW-1:0] so_u;
    @(posedge clk_in);
    #1;
    if (in_reset) begin
      check_zero("in_reset");
    end else begin
      cyc++;
      so_u      = sample_out;
      exp_valid = ((cyc % SLOT) == 0);
      check("sck",   32'(mic_sck),      32'((cyc / T) % 2));
      check("ws",    32'(mic_ws),       32'((cyc / SLOT) % 2));
      check("valid", 32'(sample_valid), 32'(exp_valid));
      if (exp_valid) begin
        s      = cyc / SLOT - 1;
        held   = top_bits(slot_word[s]);
        got[s] = so_u;
        check("channel", 32'(sample_channel), 32'(s % 2));
      end
      check("sample", 32'(so_u), 32'(held));

      if (!prev_sck && mic_sck) begin
        if (first_sck < 0) first_sck = cyc;
        if (last_rise >= 0) check("sck_period", cyc - last_rise, 2 * T);
        last_rise = cyc;
      end
      if (mic_ws !== prev_ws) begin
        check("ws_on_sck_fall", {30'd0, prev_sck, mic_sck}, 32'd2);
        if (mic_ws) begin
          if (first_ws < 0) first_ws = cyc;
          if (last_ws_rise >= 0) check("ws_period", cyc - last_ws_rise, FRAME);
          last_ws_rise = cyc;
        end
      end
      if (sample_valid) begin
        if (last_valid >= 0) check("valid_spacing", cyc - last_valid, SLOT);
        last_valid = cyc;
      end
      prev_sck = mic_sck;
      prev_ws  = mic_ws;
      drive();
    end
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst_in   = 1'b1;
    in_reset = 1'b0;
    cyc      = 0;
    clear_tracking();
    drive();
  endtask

  initial begin
    real ang;
    rst_in   = 1'b0;
    mic_data = 1'b0;
    in_reset = 1'b1;
    cyc      = 0;
    clear_tracking();
    repeat (3) step();

    // Slot 0 left, 1 right, ... ; sine stream starts at the first right slot
    // after the directed words.
    for (int i = 0; i < 64; i++) slot_word[i] = $urandom;
    slot_word[0] = 32'h1234_5678;
    slot_word[1] = 32'h8000_0000;
    slot_word[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      ang = real'(i) * 2.0 * 3.14159265358979 / 360.0;
      slot_word[7 + i] = 32'($rtoi(2147483647.0 * $sin(ang)));
    end

    release_reset();
    // 38 slots, then 10 bits of the left slot 38, landing in the high half.
    repeat (38 * SLOT + 10 * 2 * T + T + 1) step();

    check("first_sck_rise", first_sck, T);
    check("first_ws_rise",  first_ws,  SLOT);
    check("left_word",      32'(got[0]), 32'h0012_3456);
    check("right_neg_word", 32'(got[1]), 32'h0080_0000);
    check("right_m1_word",  32'(got[3]), 32'h00FF_FFFF);
    check("sine_first",     32'(got[7]), 32'd0);
    check("sck_high_before_reset", 32'(mic_sck), 32'd1);

    #2;
    rst_in   = 1'b0;
    in_reset = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (4) step();

    for (int i = 0; i < 64; i++) slot_word[i] = $urandom;
    slot_word[0] = 32'h00AB_CDEF;
    release_reset();
    repeat (2 * FRAME + 10) step();

    check("restart_first_sck_rise", first_sck, T);
    check("restart_first_ws_rise",  first_ws,  SLOT);
    check("restart_left_word",      32'(got[0]), 32'h0000_ABCD);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2s_microphones.md
# i2s_microphones

I2S receiver for a stereo pair of MEMS microphones. The block generates the I2S bit clock (`mic_sck`) and word select (`mic_ws`) from the system clock. It deserialises the shared `mic_data` line MSB-first into signed samples and presents one sample per channel slot with a single-cycle valid strobe. It sits between the board microphone pins and the audio processing pipeline.

## Interface
- `SCK_HALF_PERIOD`, default 16: system clocks per `mic_sck` half period. Must be ≥ 4. The default gives 3.125 MHz at a 100 MHz `clk_in`.
- `SAMPLE_WIDTH`, default 24: output sample width, 1..32. Takes the top bits of each 32-bit slot.
- `clk_in`  input  1  system clock, 100 MHz nominal.
- `rst_in`  input  1  reset; asynchronous, active-low.
- `mic_data`  input  1  serial data from microphones; asynchronous to `clk_in`.
- `mic_sck`  output  1  I2S bit clock, registered.
- `mic_ws`  output  1  word select, registered. 0 = left slot, 1 = right slot.
- `sample_out`  output  SAMPLE_WIDTH  signed two's-complement sample.
- `sample_channel`  output  1  channel of `sample_out`: 0 = left, 1 = right.
- `sample_valid`  output  1  one-cycle strobe; `sample_out` and `sample_channel` are new.

## Operation
- **Clock generator**
  - Half-period counter runs 0..SCK_HALF_PERIOD-1 and toggles `mic_sck` on wrap.
  - The rising edge begins the high half; the falling edge ends the bit period.
  - Full bit period is 2·SCK_HALF_PERIOD clocks.
- **Frame structure**
  - 6-bit bit counter `b`, range 0..63, increments at every `mic_sck` falling edge and wraps 63→0.
  - `mic_ws` = `b[5]`, updated on the same edge, so `mic_ws` only changes coincident with `mic_sck` falling.
  - Bit periods 0–31 form the left slot (`mic_ws`=0); periods 32–63 form the right slot (`mic_ws`=1).
- **Data capture**
  - `mic_data` passes through a 2-flop synchroniser.
  - The microphone drives slot bit k (MSB first, k=0 is MSB) after the `mic_sck` rising edge inside bit period k of the slot.
  - The block samples the synchronised data on the `clk_in` edge where `mic_sck` falls, ending that period.
  - Captured bits shift into a 32-bit register from the LSB side.
- **Output**
  - Applies on the falling edge that ends period 31 (left) or period 63 (right).
  - That edge loads `sample_out` with bits [31:32-SAMPLE_WIDTH] of the completed word, the final bit included.
  - The same edge sets `sample_channel` = slot and pulses `sample_valid` high for exactly one cycle.
  - Lower slot bits are discarded by truncation, with no rounding.
  - `sample_out` holds its value until the next update.
- **Reset**
  - Asserting `rst_in` at any time immediately forces all counters, the shift register and the synchroniser to 0.
  - `mic_sck`=0, `mic_ws`=0, `sample_out`=0, `sample_channel`=0, `sample_valid`=0.
  - A partially received word is discarded.
  - After release the block restarts at bit period 0, left slot.

## Timing
- Let T = SCK_HALF_PERIOD. Cycle 0 is the first `clk_in` rising edge after reset release.
- `mic_sck` rises at cycle T, falls at 2T, and has period 2T. It is 50% duty.
- `mic_ws` first goes high at the falling edge ending period 31, cycle 64T (1024 by default). It returns low at 128T.
- Frame period is 128T, i.e. 2048 clocks by default, giving a 48.8 kHz sample rate per channel.
- `sample_valid` is high in the cycle following the capture edge:
  - left: cycles 64T, 192T, …
  - right: cycles 128T, 256T, …
- Exactly two strobes per frame, alternating channel 0, 1.
- Input setup: `mic_data` must be stable from 2 clocks before the `mic_sck` falling edge until that edge. The synchroniser therefore captures the value present 2 cycles earlier.
- Data changing right after the `mic_sck` rising edge always satisfies this requirement.

## Test plan
- **Reset:** hold `rst_in`=0 mid-frame with `mic_sck` high.
  - Required: all outputs 0 within the same cycle.
  - After release, first `mic_sck` rise at cycle 16 and `mic_ws` rise at cycle 1024 (defaults).
- **Clock/WS:** free-run 3 frames.
  - Required: `mic_sck` period 32 clocks and `mic_ws` period 2048 clocks.
  - Every `mic_ws` edge coincides with a `mic_sck` falling edge.
  - `sample_valid` pulses are exactly 1 cycle wide, every 1024 clocks.
- **Left word:** drive 0x12345678 MSB-first, updating after each `mic_sck` rise in the left slot.
  - Required: `sample_out`=0x123456, `sample_channel`=0, `sample_valid` one cycle.
- **Right word:** drive 0x80000000 in the right slot.
  - Required: `sample_out`=0x800000 (most negative), `sample_channel`=1.
  - Then drive 0xFFFFFFFF; required: `sample_out`=0xFFFFFF (−1).
- **Sine stream:** starting after `mic_ws` first rises, drive 30 consecutive slots with word_i = trunc(0x7FFFFFFF·sin(i·2π/360)), i=0..29.
  - Required: each strobe outputs the top 24 bits of word_i, in order, with alternating channel (1, 0, 1, …).
- **Reset mid-word:** assert reset after 10 bits of a left word, release, then send 0x00ABCDEF.
  - Required: no strobe for the aborted word.
  - Next left `sample_out`=0x00ABCD.
